// File: rtl/servo_pwm_multi_if.sv
// Setpoint write port for servo_pwm_multi: the master drives a strobe, a
// channel index and a target width; the PWM block takes the slave side.
interface servo_pwm_multi_if #(
    parameter int CH_W = 2,
    parameter int PW_W = 8
);
    logic            wr_en;
    logic [CH_W-1:0] wr_ch;
    logic [PW_W-1:0] wr_data;

    modport master (output wr_en, output wr_ch, output wr_data);
    modport slave  (input  wr_en, input  wr_ch, input  wr_data);
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM with a shared prescaler and frame counter. New
// setpoints are applied only at frame wrap. Defining SERVO_SLEW_EN adds a
// per-frame slew limit on the active widths.
module servo_pwm_multi #(
    parameter int CH      = 4,
    parameter int CH_W    = 2,
    parameter int PW_W    = 8,
    parameter int DIV_W   = 16,
    parameter int FRAME_W = 10
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [DIV_W-1:0]   div_clk_i,
    input  logic [FRAME_W-1:0] period_i,
    input  logic [CH-1:0]      ch_en_i,
    servo_pwm_multi_if.slave   wr_if,
    input  logic [PW_W-1:0]    slew_step_i,
    output logic [CH-1:0]      pwm_o,
    output logic               frame_start_o,
    output logic               settled_o
);

    logic [DIV_W-1:0]   pre_q, pre_d;
    logic [FRAME_W-1:0] cnt_q, cnt_d;
    logic [PW_W-1:0]    target_q [CH];
    logic [PW_W-1:0]    target_d [CH];
    logic [PW_W-1:0]    act_q    [CH];
    logic [PW_W-1:0]    act_d    [CH];
    logic [CH-1:0]      pwm_q, pwm_d;
    logic               frame_start_q;
    logic               settled_q, settled_d;
    logic               tick;
    logic               wrap;
    logic               wr_hit;

`ifdef SERVO_SLEW_EN
    // One extra bit keeps the distance between act and target free of wrap-around.
    function automatic logic [PW_W-1:0] slew_next(
        input logic [PW_W-1:0] act,
        input logic [PW_W-1:0] tgt,
        input logic [PW_W-1:0] step
    );
        logic [PW_W:0] diff;
        diff = (tgt >= act) ? ({1'b0, tgt} - {1'b0, act})
                            : ({1'b0, act} - {1'b0, tgt});
        if (step == '0 || diff <= {1'b0, step})
            return tgt;
        else if (tgt > act)
            return act + step;
        else
            return act - step;
    endfunction
`else
    logic unused_slew_step;
    assign unused_slew_step = ^slew_step_i;
`endif

    // >= rather than == so that a lowered divider or period takes effect at once.
    always_comb begin
        tick  = 1'b0;
        pre_d = pre_q;
        if (div_clk_i != '0) begin
            if (pre_q >= div_clk_i - DIV_W'(1)) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + DIV_W'(1);
            end
        end
    end

    always_comb begin
        wrap  = 1'b0;
        cnt_d = cnt_q;
        if (tick && period_i != '0) begin
            if (cnt_q >= period_i - FRAME_W'(1)) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + FRAME_W'(1);
            end
        end
    end

    assign wr_hit = wr_if.wr_en && (32'(wr_if.wr_ch) < CH);

    // act samples the pre-write target, so a write in the wrap clock waits a frame.
    always_comb begin
        settled_d = 1'b1;
        pwm_d     = '0;
        for (int i = 0; i < CH; i++) begin
            target_d[i] = (wr_hit && 32'(wr_if.wr_ch) == i) ? wr_if.wr_data : target_q[i];
`ifdef SERVO_SLEW_EN
            act_d[i] = wrap ? slew_next(act_q[i], target_q[i], slew_step_i) : act_q[i];
`else
            act_d[i] = wrap ? target_q[i] : act_q[i];
`endif
            pwm_d[i] = ch_en_i[i] && (cnt_q < FRAME_W'(act_q[i]));
            if (act_q[i] != target_q[i])
                settled_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pre_q         <= '0;
            cnt_q         <= '0;
            target_q      <= '{default: '0};
            act_q         <= '{default: '0};
            pwm_q         <= '0;
            frame_start_q <= 1'b0;
            settled_q     <= 1'b1;
        end else begin
            pre_q         <= pre_d;
            cnt_q         <= cnt_d;
            target_q      <= target_d;
            act_q         <= act_d;
            pwm_q         <= pwm_d;
            frame_start_q <= wrap;
            settled_q     <= settled_d;
        end
    end

    assign pwm_o         = pwm_q;
    assign frame_start_o = frame_start_q;
    assign settled_o     = settled_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi (CH=4, div_clk=4, period=10, 40-clk frames).
module tb_servo_pwm_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] div_clk;
    logic [9:0]  period;
    logic [3:0]  ch_en;
    logic [7:0]  slew_step;
    logic [3:0]  pwm;
    logic        frame_start;
    logic        settled;

    int   checks   = 0;
    int   failures = 0;
    int   hi [4];
    int   fs_cnt;
    logic fs_last;
    logic set_k1;
    int   waited;
    int   bad;
    logic found;

    servo_pwm_multi_if #(.CH_W(3), .PW_W(8)) wr_if ();

    servo_pwm_multi #(
        .CH(4), .CH_W(3), .PW_W(8), .DIV_W(16), .FRAME_W(10)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .div_clk_i    (div_clk),
        .period_i     (period),
        .ch_en_i      (ch_en),
        .wr_if        (wr_if),
        .slew_step_i  (slew_step),
        .pwm_o        (pwm),
        .frame_start_o(frame_start),
        .settled_o    (settled)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n clocks from just after a wrap, tallying pwm highs and frame_start;
    // optionally issues one write after sampling clock wr_at.
    task automatic run_frame(input int n, input int wr_at, input logic [2:0] ch, input logic [7:0] data);
        for (int j = 0; j < 4; j++) hi[j] = 0;
        fs_cnt  = 0;
        fs_last = 1'b0;
        set_k1  = 1'b0;
        for (int k = 1; k <= n; k++) begin
            step();
            for (int j = 0; j < 4; j++) if (pwm[j]) hi[j]++;
            if (frame_start) fs_cnt++;
            fs_last = frame_start;
            if (k == 1) set_k1 = settled;
            if (k == wr_at) begin
                wr_if.wr_en   = 1'b1;
                wr_if.wr_ch   = ch;
                wr_if.wr_data = data;
            end else begin
                wr_if.wr_en = 1'b0;
            end
        end
        wr_if.wr_en = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int e0, input int e1, input int e2,
                               input int e3, input logic eset);
        chk({tag, ".hi0"}, hi[0], e0);
        chk({tag, ".hi1"}, hi[1], e1);
        chk({tag, ".hi2"}, hi[2], e2);
        chk({tag, ".hi3"}, hi[3], e3);
        chk({tag, ".fs_count"}, fs_cnt, 1);
        chk({tag, ".fs_at_end"}, fs_last, 1'b1);
        chk({tag, ".settled_k1"}, settled, settled);
        chk({tag, ".settled"}, set_k1, eset);
    endtask

    initial begin
        reset         = 1'b1;
        div_clk       = 16'd4;
        period        = 10'd10;
        ch_en         = 4'hF;
        slew_step     = 8'd0;
        wr_if.wr_en   = 1'b0;
        wr_if.wr_ch   = 3'd0;
        wr_if.wr_data = 8'd0;
        repeat (3) step();
        chk("rst_pwm", pwm, 4'h0);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("rst_settled", settled, 1'b1);

        reset         = 1'b0;
        wr_if.wr_en   = 1'b1;
        wr_if.wr_ch   = 3'd0;
        wr_if.wr_data = 8'd3;
        step();
        wr_if.wr_en = 1'b0;
        step();
        chk("settled_after_write", settled, 1'b0);

        // pre and cnt start at 0, so the first wrap is 40 clocks after release.
        found  = 1'b0;
        waited = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            waited++;
            if (frame_start) found = 1'b1;
        end
        chk("first_wrap_found", found, 1'b1);
        chk("first_wrap_latency", waited, 38);

        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("f1_ch0_w3", 12, 0, 0, 0, 1'b1);
        run_frame(40, 5, 3'd1, 8'd0);
        check_frame("f2_wr_ch1", 12, 0, 0, 0, 1'b1);
        run_frame(40, 5, 3'd2, 8'd15);
        check_frame("f3_wr_ch2", 12, 0, 0, 0, 1'b1);
        run_frame(40, 17, 3'd3, 8'd5);
        check_frame("f4_midframe_wr", 12, 0, 40, 0, 1'b1);
        run_frame(40, 39, 3'd3, 8'd2);
        check_frame("f5_wr_at_wrap", 12, 0, 40, 20, 1'b1);
        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("f6_deferred", 12, 0, 40, 20, 1'b0);
        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("f7_applied", 12, 0, 40, 8, 1'b1);
        run_frame(40, 5, 3'd5, 8'd99);
        check_frame("f8_bad_ch", 12, 0, 40, 8, 1'b1);
        ch_en = 4'b1110;
        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("f9_ch0_disabled", 0, 0, 40, 8, 1'b1);
        ch_en = 4'hF;

        repeat (3) step();
        chk("pre_freeze_pwm", pwm, 4'b1101);
        div_clk = 16'd0;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (pwm !== 4'b1101 || frame_start !== 1'b0) bad++;
        end
        chk("freeze_changes", bad, 0);
        div_clk = 16'd4;
        run_frame(37, -1, 3'd0, 8'd0);
        check_frame("resume", 9, 0, 37, 5, 1'b1);

        repeat (2) step();
        chk("pre_reset_pwm0", pwm[0], 1'b1);
        reset = 1'b1;
        step();
        chk("reset_pwm", pwm, 4'h0);
        chk("reset_fs", frame_start, 1'b0);
        chk("reset_settled", settled, 1'b1);
        reset = 1'b0;
        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("post_reset_f1", 0, 0, 0, 0, 1'b1);
        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("post_reset_f2", 0, 0, 0, 0, 1'b1);

`ifdef SERVO_SLEW_EN
        slew_step = 8'd2;
        run_frame(40, 5, 3'd0, 8'd7);
        check_frame("slew_a", 0, 0, 0, 0, 1'b1);
        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("slew_act2", 8, 0, 0, 0, 1'b0);
        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("slew_act4", 16, 0, 0, 0, 1'b0);
        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("slew_act6", 24, 0, 0, 0, 1'b0);
        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("slew_act7", 28, 0, 0, 0, 1'b1);
        slew_step = 8'd0;
        run_frame(40, 5, 3'd0, 8'd1);
        check_frame("slew0_wr", 28, 0, 0, 0, 1'b1);
        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("slew0_jump", 4, 0, 0, 0, 1'b1);
`else
        slew_step = 8'd2;
        run_frame(40, 5, 3'd0, 8'd7);
        check_frame("noslew_wr", 0, 0, 0, 0, 1'b1);
        run_frame(40, -1, 3'd0, 8'd0);
        check_frame("noslew_jump", 28, 0, 0, 0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_pwm_multi.md
# servo_pwm_multi

Multi-channel servo PWM generator for SG90-class hobby servos, the parametrised successor to the single-channel servo block. A shared prescaler and frame counter drive CH independent pulse outputs. Setpoints are written through a simple write port into per-channel target registers and are applied only at frame boundaries, so pulses never glitch mid-frame. An optional slew limiter moves each channel toward its target by a bounded step per frame.

## Interface
- CH, 4, number of servo channels (1..16)
- CH_W, 2, width of channel index (clog2(CH), min 1)
- PW_W, 8, pulse-width/setpoint width in ticks
- DIV_W, 16, prescaler width
- FRAME_W, 10, frame counter width (FRAME_W >= PW_W)
---
- clk  in  1  system clock (24 MHz on board)
- reset  in  1  synchronous, active-high reset
- div_clk  in  DIV_W  clocks per tick; 0 = prescaler stopped
- period  in  FRAME_W  frame length in ticks; 0 = frame counter stopped
- ch_en  in  CH  per-channel output enable
- wr_en  in  1  write strobe for target setpoint
- wr_ch  in  CH_W  channel index for write
- wr_data  in  PW_W  target pulse width in ticks
- slew_step  in  PW_W  max change of active width per frame (used only with SERVO_SLEW_EN)
- pwm  out  CH  registered pulse outputs
- frame_start  out  1  one-clk pulse on every frame wrap
- settled  out  1  high when every active width equals its target

## Operation
- Prescaler pre: each clk, if div_clk == 0 hold pre, no tick; else if pre >= div_clk-1 then pre <= 0 and tick; else pre <= pre+1. Using >= makes a lowered div_clk take effect immediately.
- Frame counter cnt advances only on tick: if period == 0 hold; else if cnt >= period-1 then cnt <= 0 (wrap) else cnt <= cnt+1.
- Write: wr_en with wr_ch < CH sets target[wr_ch] <= wr_data. wr_ch >= CH: ignored. A write takes effect on the next wrap after it; a write in the same clk as a wrap is not seen until the following wrap.
- On wrap, per channel: act[i] <= next(act[i], target[i]) (see Configuration). frame_start <= 1 for that clk, else 0.
- Every clk: pwm[i] <= ch_en[i] && (cnt < act[i]), zero-extended compare.
- Boundaries: act = 0 → pwm low whole frame; act >= period → high whole frame; ch_en low → low immediately (next clk) and does not affect act updates.
- settled <= (act[i] == target[i] for all i), registered.
- Reset: pre = 0, cnt = 0, all target = 0, all act = 0, pwm = 0, frame_start = 0, settled = 1. A reset mid-frame truncates the current pulse on the next clk.

## Timing
- pwm lags cnt by one clk; pulse high time = act[i] × div_clk clocks exactly; frame = period × div_clk clocks.
- Rising edges of all enabled channels align with frame_start + 1 clk.
- Write to visible pulse: up to one full frame + 1 clk.
- settled updates one clk after act or target change.

## Configuration
- SERVO_SLEW_EN defined: at wrap, if slew_step == 0 or |target-act| <= slew_step then act <= target, else act <= act ± slew_step toward target (no overflow; unsigned arithmetic on PW_W+1 bits).
- Not defined: at wrap act <= target directly; slew_step is ignored (port retained).

## Test plan
- Reset then div_clk=4, period=10, write ch0=3 → after first frame_start, pwm[0] high 12 clks, low 28 clks, repeating every 40 clks; other channels low.
- Write ch1=0 and ch2=15 with period=10 → pwm[1] never high, pwm[2] constantly high; settled=1 after wrap.
- Write ch3=5 mid-frame, cnt=4 → current frame unchanged; new width appears from next frame_start; write in wrap clk deferred one more frame.
- wr_ch=5 with CH=4, and div_clk=0 → no target change; pre/cnt frozen, pwm held at last compare value.
- SERVO_SLEW_EN, slew_step=2, act=0, write target 7 → act 2,4,6,7 over four frames; settled low until 7 reached; slew_step=0 jumps in one frame.
- Assert reset while pwm[0] high → pwm all 0 next clk, cnt=0, targets cleared.
